// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with a valid/ready handshake on both sides.
// Single-cycle ops (ADD..SBC) finish one cycle after acceptance. MULU (shift-add)
// and DIVU (restoring) take DATA_W iterations. Results are held until accepted.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  request handshake (ready only in IDLE)
//   func, a, b, cin operation code, operands, carry/borrow in
//   out_valid/ready result handshake (valid only in DONE)
//   y, y_hi         result / product low,high / quotient,remainder
//   flags           {N,Z,C,V}
//   err             illegal opcode was accepted
//   busy            iterating a MULU/DIVU
module alu_seq #(
  parameter int DATA_W    = 16,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        func,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] y_hi,
  output logic [3:0]        flags,
  output logic              err,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int W  = DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q, hi_d;   // partial product high / remainder
  logic [W-1:0]  lo_q, lo_d;   // multiplier / dividend shifting into quotient
  logic [W-1:0]  dv_q, dv_d;   // multiplicand / divisor
  logic [W-1:0]  a_q, a_d;     // original dividend for the divide-by-zero result
  logic          mul_q, mul_d;
  logic [W-1:0]  y_q, y_d, yh_q, yh_d;
  logic [3:0]    fl_q, fl_d;
  logic          err_q, err_d;

  // ---------------- single-cycle datapath ----------------
  logic [W:0]   r;
  logic [W-1:0] alu_y;
  logic         alu_c, alu_v, alu_err, is_md, cy;
  logic [3:0]   alu_fl;

  always_comb begin
    r       = '0;
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    is_md   = 1'b0;
    cy      = (func == 4'd10 || func == 4'd11) ? cin : 1'b0;
    case (func)
      4'd0, 4'd10: begin
        r     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cy};
        alu_y = r[W-1:0];
        alu_c = r[W];
        alu_v = (a[W-1] == b[W-1]) && (alu_y[W-1] != a[W-1]);
      end
      4'd1, 4'd11: begin
        // borrow appears as the wrapped top bit of the W+1-bit difference
        r     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cy};
        alu_y = r[W-1:0];
        alu_c = r[W];
        alu_v = (a[W-1] != b[W-1]) && (alu_y[W-1] != a[W-1]);
      end
      4'd2: alu_y = b;
      4'd3: alu_y = ~b;
      4'd4: alu_y = a & b;
      4'd5: alu_y = a | b;
      4'd6: alu_y = a ^ b;
      // right shifts append a guard bit so the last bit shifted out lands in C
      4'd7: begin
        r     = $signed({a, 1'b0}) >>> b;
        alu_y = r[W:1];
        alu_c = r[0];
      end
      4'd8: begin
        r     = {a, 1'b0} >> b;
        alu_y = r[W:1];
        alu_c = r[0];
      end
      4'd9: begin
        r     = {1'b0, a} << b;
        alu_y = r[W-1:0];
        alu_c = r[W];
      end
      4'd12, 4'd13: begin
        if (MULDIV_EN) is_md = 1'b1;
        else           alu_err = 1'b1;
      end
      default: alu_err = 1'b1;
    endcase
    alu_fl = alu_err ? 4'b0000 : {alu_y[W-1], alu_y == '0, alu_c, alu_v};
  end

  // ---------------- iteration step ----------------
  logic [W:0]   m_sum;
  logic [W+1:0] d_diff;
  logic [W-1:0] st_hi, st_lo;

  always_comb begin
    m_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
    d_diff = {1'b0, hi_q, lo_q[W-1]} - {2'b00, dv_q};
    if (mul_q) begin
      st_hi = m_sum[W:1];
      st_lo = {m_sum[0], lo_q[W-1:1]};
    end else if (!d_diff[W+1]) begin
      st_hi = d_diff[W-1:0];
      st_lo = {lo_q[W-2:0], 1'b1};
    end else begin
      st_hi = {hi_q[W-2:0], lo_q[W-1]};
      st_lo = {lo_q[W-2:0], 1'b0};
    end
  end

  // ---------------- control ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dv_d    = dv_q;
    a_d     = a_q;
    mul_d   = mul_q;
    y_d     = y_q;
    yh_d    = yh_q;
    fl_d    = fl_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        if (is_md) begin
          state_d = S_BUSY;
          cnt_d   = CW'(DATA_W);
          mul_d   = (func == 4'd12);
          hi_d    = '0;
          lo_d    = (func == 4'd12) ? b : a;
          dv_d    = (func == 4'd12) ? a : b;
          a_d     = a;
        end else begin
          state_d = S_DONE;
          y_d     = alu_y;
          yh_d    = '0;
          fl_d    = alu_fl;
          err_d   = alu_err;
        end
      end
      S_BUSY: begin
        hi_d  = st_hi;
        lo_d  = st_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // final iteration result goes straight into the output registers
          state_d = S_DONE;
          err_d   = 1'b0;
          if (!mul_q && dv_q == '0) begin
            y_d  = '1;
            yh_d = a_q;
            fl_d = 4'b1001;
          end else begin
            y_d  = st_lo;
            yh_d = st_hi;
            fl_d = {st_lo[W-1], st_lo == '0, mul_q && (st_hi != '0), 1'b0};
          end
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dv_q    <= '0;
      a_q     <= '0;
      mul_q   <= 1'b0;
      y_q     <= '0;
      yh_q    <= '0;
      fl_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dv_q    <= dv_d;
      a_q     <= a_d;
      mul_q   <= mul_d;
      y_q     <= y_d;
      yh_q    <= yh_d;
      fl_q    <= fl_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign y         = y_q;
  assign y_hi      = yh_q;
  assign flags     = fl_q;
  assign err       = err_q;
endmodule
